// File: rtl/float_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : float_div_sequencer
// Purpose  : Floating-point divide sequencer built around an external mantissa
//            divider. Operands are accepted over a valid/ready handshake,
//            unpacked and classified. Special operands (zero, inf, NaN,
//            flushed subnormals) are resolved locally. All other operands are
//            divided by the external divider. The quotient is then
//            normalized, truncated, range-checked and packed. The result is
//            held on a valid/ready output until it is consumed.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            in_valid/in_ready  - operand handshake (ready only in IDLE)
//            op_a, op_b         - packed dividend / divisor {sign, exp, man}
//            out_valid/out_ready- result handshake
//            result             - packed quotient
//            div_start          - one-cycle start pulse to mantissa divider
//            div_dividend/div_divisor - {1, man} operands to divider
//            div_quotient/div_done    - divider result and done pulse
// Revision : 1.0 - initial release
// ============================================================================
module float_div_sequencer #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   div_start,
    output logic [MAN_W:0]         div_dividend,
    output logic [MAN_W:0]         div_divisor,
    input  logic [MAN_W:0]         div_quotient,
    input  logic                   div_done
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLASS = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NORM  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [MAN_W:0]   r_quot;
    logic [W-1:0]     r_result;
    logic [MAN_W:0]   r_dividend;
    logic [MAN_W:0]   r_divisor;

    // ---------------- operand unpack and classification ----------------
    logic               w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_ma, w_mb;
    logic               w_a_zero, w_a_inf, w_a_nan;
    logic               w_b_zero, w_b_inf, w_b_nan;
    logic               w_special;
    logic [W-1:0]       w_special_res;

    assign w_sa   = r_a[W-1];
    assign w_sb   = r_b[W-1];
    assign w_ea   = r_a[W-2:MAN_W];
    assign w_eb   = r_b[W-2:MAN_W];
    assign w_ma   = r_a[MAN_W-1:0];
    assign w_mb   = r_b[MAN_W-1:0];
    assign w_sign = w_sa ^ w_sb;

    // exp==0 is treated as zero regardless of mantissa (subnormal flush)
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (w_ma == '0);
    assign w_b_inf  = (w_eb == '1) && (w_mb == '0);
    assign w_a_nan  = (w_ea == '1) && (w_ma != '0);
    assign w_b_nan  = (w_eb == '1) && (w_mb != '0);

    assign w_special = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;

    always_comb begin
        w_special_res = {w_sign, {(W-1){1'b0}}};
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            // canonical NaN: positive, quiet bit set
            w_special_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (w_a_inf || w_b_zero) begin
            w_special_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            w_special_res = {w_sign, {(W-1){1'b0}}};
        end
    end

    // ---------------- normal path: exponent, normalize, range ----------------
    logic signed [EW-1:0] w_e;
    logic signed [EW-1:0] w_exp_n;
    logic [MAN_W-1:0]     w_man_n;
    logic [W-1:0]         w_norm_res;

    // Both exponents are normal here, so the difference plus bias fits EW bits
    assign w_e = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + $signed(EW'(BIAS));

    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift
    assign w_man_n = r_quot[MAN_W] ? r_quot[MAN_W-1:0] : {r_quot[MAN_W-2:0], 1'b0};
    assign w_exp_n = r_quot[MAN_W] ? w_e : (w_e - $signed(EW'(1)));

    always_comb begin
        w_norm_res = {w_sign, w_exp_n[EXP_W-1:0], w_man_n};
        if (w_exp_n >= $signed(EW'((1 << EXP_W) - 1))) begin
            w_norm_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_exp_n <= $signed(EW'(0))) begin
            w_norm_res = {w_sign, {(W-1){1'b0}}};
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_CLASS;
            S_CLASS: w_next = w_special ? S_OUT : S_START;
            S_START: w_next = S_WAIT;
            S_WAIT:  if (div_done)  w_next = S_NORM;
            S_NORM:  w_next = S_OUT;
            S_OUT:   if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        div_start = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_START: div_start = 1'b1;
            S_OUT:   out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quot     <= '0;
            r_result   <= '0;
        end else begin
            // divider operands are loaded with the operands so they are
            // already stable in CLASS and stay put until the next accept
            if (r_state == S_IDLE && in_valid) begin
                r_a        <= op_a;
                r_b        <= op_b;
                r_dividend <= {1'b1, op_a[MAN_W-1:0]};
                r_divisor  <= {1'b1, op_b[MAN_W-1:0]};
            end
            if (r_state == S_WAIT && div_done) begin
                r_quot <= div_quotient;
            end
            if (r_state == S_CLASS && w_special) begin
                r_result <= w_special_res;
            end
            if (r_state == S_NORM) begin
                r_result <= w_norm_res;
            end
        end
    end

    assign result       = r_result;
    assign div_dividend = r_dividend;
    assign div_divisor  = r_divisor;

endmodule
`default_nettype wire
